hilo_commit_unit: RTL and testbench

- Sits directly downstream of the EX-stage ALU and owns the architectural 64-bit HiLo register.
- Consumes the ALU's Hi/Lo/Write outputs and carries them through MEM and WB pipeline slots. The architectural register is updated only at WB.
- Drives the ALU's 64-bit HiLo input, so back-to-back mult/madd/msub/mthi/mtlo/mfhi/mflo sequences see the newest value.
- Handles stall and flush, tracks in-flight writes, and counts commits.

---
 rtl/hilo_commit_unit.sv | 100 ++++++++++
 tb/tb_hilo_commit_unit.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hilo_commit_unit.sv
// HiLo commit unit: carries ALU Hi/Lo writes through MEM and WB slots,
// owns the architectural 64-bit HiLo register and feeds HiLo back to EX.
//
// Ports:
//   Clk, Rst          clock, synchronous active-high reset
//   Stall             freeze every register (commit and counter too)
//   Flush             squash the write request of the EX instruction
//   Write, Hi, Lo     ALU Hi/Lo write request and data from EX
//   HiLoRead          EX instruction reads HiLo
//   HiLo              value for the ALU HiLo input, {Hi,Lo}
//   HiLoArch          committed architectural {Hi,Lo}
//   Pending           a write is in flight in MEM or WB
//   HazardStall       HiLo read-after-write stall request
//   CommitCount       number of commits, wraps at 2^CNT_W
//
// Build option: define HILO_BYPASS_EN to forward in-flight writes to HiLo
// (HazardStall then stays 0). Without it HiLo is the architectural value
// and HazardStall = HiLoRead & Pending.

module hilo_commit_unit #(
    parameter int CNT_W = 16
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Stall,
    input  logic             Flush,
    input  logic             Write,
    input  logic [31:0]      Hi,
    input  logic [31:0]      Lo,
    input  logic             HiLoRead,
    output logic [63:0]      HiLo,
    output logic [63:0]      HiLoArch,
    output logic             Pending,
    output logic             HazardStall,
    output logic [CNT_W-1:0] CommitCount
);

    typedef struct packed {
        logic        valid;
        logic [31:0] hi;
        logic [31:0] lo;
    } slot_t;

    slot_t            mem_q;
    slot_t            wb_q;
    logic [31:0]      arch_hi;
    logic [31:0]      arch_lo;
    logic [CNT_W-1:0] commit_cnt;

    // Data is captured even when the request is not valid; only the
    // valid bit decides whether the slot will ever be seen or committed.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            mem_q      <= '0;
            wb_q       <= '0;
            arch_hi    <= '0;
            arch_lo    <= '0;
            commit_cnt <= '0;
        end else if (!Stall) begin
            mem_q.valid <= Write & ~Flush;
            mem_q.hi    <= Hi;
            mem_q.lo    <= Lo;
            wb_q        <= mem_q;
            if (wb_q.valid) begin
                arch_hi    <= wb_q.hi;
                arch_lo    <= wb_q.lo;
                commit_cnt <= commit_cnt + CNT_W'(1);
            end
        end
    end

    assign HiLoArch    = {arch_hi, arch_lo};
    assign Pending     = mem_q.valid | wb_q.valid;
    assign CommitCount = commit_cnt;

`ifdef HILO_BYPASS_EN
    logic [63:0] fwd;
    logic        unused_read;

    // Youngest in-flight write wins.
    always_comb begin
        fwd = {arch_hi, arch_lo};
        if (mem_q.valid) begin
            fwd = {mem_q.hi, mem_q.lo};
        end else if (wb_q.valid) begin
            fwd = {wb_q.hi, wb_q.lo};
        end
    end

    assign unused_read = HiLoRead;
    assign HiLo        = fwd;
    assign HazardStall = 1'b0;
`else
    // Without forwarding a reader must wait until every in-flight
    // write has committed.
    assign HiLo        = {arch_hi, arch_lo};
    assign HazardStall = HiLoRead & Pending;
`endif

endmodule

// File: tb/tb_hilo_commit_unit.sv
// Directed bench for hilo_commit_unit with an in-bench history model
// compared every cycle, plus literal checks on key points.

module tb_hilo_commit_unit;

    logic        Clk;
    logic        Rst;
    logic        Stall;
    logic        Flush;
    logic        Write;
    logic [31:0] Hi;
    logic [31:0] Lo;
    logic        HiLoRead;
    logic [63:0] HiLo;
    logic [63:0] HiLoArch;
    logic        Pending;
    logic        HazardStall;
    logic [15:0] CommitCount;

    int checks = 0;
    int errors = 0;

    hilo_commit_unit #(.CNT_W(16)) dut (
        .Clk(Clk),
        .Rst(Rst),
        .Stall(Stall),
        .Flush(Flush),
        .Write(Write),
        .Hi(Hi),
        .Lo(Lo),
        .HiLoRead(HiLoRead),
        .HiLo(HiLo),
        .HiLoArch(HiLoArch),
        .Pending(Pending),
        .HazardStall(HazardStall),
        .CommitCount(CommitCount)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // Model: one history entry per advancing edge since reset.
    // Entry k was captured at advancing edge k; after n edges entry n-1
    // is in MEM, n-2 in WB, and entries up to n-3 are committed.
    bit          hv[$];
    logic [63:0] hd[$];
    bit          live = 0;

    always @(posedge Clk) begin
        if (Rst) begin
            hv.delete();
            hd.delete();
            live = 1;
        end else if (!Stall) begin
            hv.push_back(Write & ~Flush);
            hd.push_back({Hi, Lo});
        end
    end

    function automatic logic [63:0] m_arch();
        logic [63:0] v = '0;
        for (int j = 0; j <= hv.size() - 3; j++)
            if (hv[j]) v = hd[j];
        return v;
    endfunction

    function automatic int m_count();
        int c = 0;
        for (int j = 0; j <= hv.size() - 3; j++)
            if (hv[j]) c++;
        return c;
    endfunction

    function automatic bit m_mem_v();
        return hv.size() >= 1 && hv[hv.size() - 1];
    endfunction

    function automatic bit m_wb_v();
        return hv.size() >= 2 && hv[hv.size() - 2];
    endfunction

    function automatic logic [63:0] m_hilo();
`ifdef HILO_BYPASS_EN
        if (m_mem_v()) return hd[hd.size() - 1];
        if (m_wb_v()) return hd[hd.size() - 2];
`endif
        return m_arch();
    endfunction

    function automatic bit m_hazard();
`ifdef HILO_BYPASS_EN
        return 1'b0;
`else
        return HiLoRead && (m_mem_v() || m_wb_v());
`endif
    endfunction

    task automatic chk(input string name, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", name, got, exp,
                     $time);
        end
    endtask

    always @(negedge Clk) begin
        if (live) begin
            chk("m_hilo", HiLo, m_hilo());
            chk("m_arch", HiLoArch, m_arch());
            chk("m_pending", 64'(Pending), 64'(m_mem_v() || m_wb_v()));
            chk("m_hazard", 64'(HazardStall), 64'(m_hazard()));
            chk("m_count", 64'(CommitCount), 64'(16'(m_count())));
        end
    end

    task automatic drive(input logic w, input logic f, input logic s,
                         input logic r, input logic [63:0] v);
        Write    = w;
        Flush    = f;
        Stall    = s;
        HiLoRead = r;
        Hi       = v[63:32];
        Lo       = v[31:0];
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 64'h0);
    endtask

    localparam logic [63:0] V1 = 64'h00000001_FFFFFFFE;
    localparam logic [63:0] VA = 64'h11111111_22222222;
    localparam logic [63:0] VB = 64'h33333333_44444444;
    localparam logic [63:0] VF = 64'hDEADBEEF_CAFEBABE;
    localparam logic [63:0] VC = 64'h55555555_66666666;
    localparam logic [63:0] VD = 64'h77777777_88888888;
    localparam logic [63:0] VE = 64'h99999999_AAAAAAAA;

`ifdef HILO_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    initial begin
        Rst = 1'b1;
        idle();
        tick();
        Rst = 1'b0;
        repeat (3) tick();
        chk("rst_hilo", HiLo, 64'h0);
        chk("rst_arch", HiLoArch, 64'h0);
        chk("rst_pending", 64'(Pending), 64'h0);
        chk("rst_count", 64'(CommitCount), 64'h0);

        // single write
        drive(1, 0, 0, 0, V1);
        tick();
        idle();
        chk("w1_pending", 64'(Pending), 64'h1);
        chk("w1_hilo", HiLo, BYP ? V1 : 64'h0);
        chk("w1_arch0", HiLoArch, 64'h0);
        tick();
        chk("w1_arch_wb", HiLoArch, 64'h0);
        tick();
        chk("w1_arch", HiLoArch, V1);
        chk("w1_count", 64'(CommitCount), 64'h1);
        chk("w1_hilo_c", HiLo, V1);

        // back to back A, B
        drive(1, 0, 0, 0, VA);
        tick();
        chk("ab_hilo_a", HiLo, BYP ? VA : V1);
        drive(1, 0, 0, 0, VB);
        tick();
        idle();
        chk("ab_hilo_b", HiLo, BYP ? VB : V1);
        tick();
        chk("ab_arch_a", HiLoArch, VA);
        tick();
        chk("ab_arch_b", HiLoArch, VB);
        chk("ab_count", 64'(CommitCount), 64'h3);

        // flushed write
        drive(1, 1, 0, 0, VF);
        tick();
        idle();
        chk("fl_pending", 64'(Pending), 64'h0);
        chk("fl_hilo", HiLo, VB);
        repeat (2) tick();
        chk("fl_arch", HiLoArch, VB);
        chk("fl_count", 64'(CommitCount), 64'h3);

        // stall mid-flight; a write and a flush offered during the stall
        drive(1, 0, 0, 0, VC);
        tick();
        drive(0, 0, 1, 0, 64'h0);
        tick();
        drive(1, 1, 1, 0, VE);
        tick();
        drive(1, 0, 1, 0, VE);
        tick();
        chk("st_pending", 64'(Pending), 64'h1);
        chk("st_arch", HiLoArch, VB);
        chk("st_count", 64'(CommitCount), 64'h3);
        chk("st_hilo", HiLo, BYP ? VC : VB);
        idle();
        tick();
        chk("st_arch_wb", HiLoArch, VB);
        tick();
        chk("st_arch", HiLoArch, VC);
        chk("st_count2", 64'(CommitCount), 64'h4);

        // read after write
        drive(1, 0, 0, 0, VD);
        tick();
        drive(0, 0, 0, 1, 64'h0);
        #1;
        chk("hz_1", 64'(HazardStall), BYP ? 64'h0 : 64'h1);
        chk("hz_hilo1", HiLo, BYP ? VD : VC);
        tick();
        chk("hz_2", 64'(HazardStall), BYP ? 64'h0 : 64'h1);
        tick();
        chk("hz_3", 64'(HazardStall), 64'h0);
        chk("hz_hilo", HiLo, VD);
        chk("hz_count", 64'(CommitCount), 64'h5);
        idle();
        tick();

        // mid-flight reset drops everything in the slots
        drive(1, 0, 0, 0, VE);
        tick();
        Rst = 1'b1;
        idle();
        tick();
        Rst = 1'b0;
        repeat (2) tick();
        chk("rr_arch", HiLoArch, 64'h0);
        chk("rr_count", 64'(CommitCount), 64'h0);
        chk("rr_pending", 64'(Pending), 64'h0);

        @(negedge Clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
